// File: rtl/clk_gen_multi_if.sv
// Control/status bundle for clk_gen_multi: ratio loading, divided clocks, strobes and lock.
// Handshake: load is a one-cycle request sampled on clk_in1; load_ack is a one-cycle completion pulse.
interface clk_gen_multi_if #(
    parameter int NUM_CH = 4,
    parameter int DIV_W  = 8
);
    logic                    enable;
    logic [NUM_CH*DIV_W-1:0] div_ratio;
    logic                    load;
    logic                    load_ack;
    logic [NUM_CH-1:0]       clk_out;
    logic [NUM_CH-1:0]       clk_en;
    logic                    locked;
    logic [1:0]              state_dbg;

    modport master (
        output enable, div_ratio, load,
        input  load_ack, clk_out, clk_en, locked, state_dbg
    );

    modport slave (
        input  enable, div_ratio, load,
        output load_ack, clk_out, clk_en, locked, state_dbg
    );
endinterface

// File: rtl/clk_gen_multi.sv
// Multi-channel fabric clock divider with run-time ratios, per-channel enable strobes and lock status.
// Define CLK_GEN_MULTI_ALIGN_EN to make running loads switch all channels together at channel 0's wrap.
module clk_gen_multi #(
    parameter int NUM_CH      = 4,
    parameter int DIV_W       = 8,
    parameter int LOCK_CYCLES = 16
) (
    input  logic           clk_in1,
    input  logic           resetn,
    clk_gen_multi_if.slave bus
);
    localparam int LCW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        LOCKED = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [LCW-1:0]    lock_cnt_q, lock_cnt_d;
    logic [DIV_W-1:0]  act_q [NUM_CH];
    logic [DIV_W-1:0]  act_d [NUM_CH];
    logic [DIV_W-1:0]  shd_q [NUM_CH];
    logic [DIV_W-1:0]  shd_d [NUM_CH];
    logic [DIV_W-1:0]  cnt_q [NUM_CH];
    logic [DIV_W-1:0]  cnt_d [NUM_CH];
    logic              pend_q, pend_d;
    logic [NUM_CH-1:0] adopted_q, adopted_d;
    logic [NUM_CH-1:0] clk_out_q, clk_out_d;
    logic [NUM_CH-1:0] clk_en_q, clk_en_d;
    logic              load_ack_q, load_ack_d;
    logic              locked_q, locked_d;

    logic [NUM_CH-1:0] at_wrap;
    logic [NUM_CH-1:0] adopt;
    logic [DIV_W:0]    half [NUM_CH];
    logic              running;

    // Ratios 0 and 1 cannot make a clock; treat them as divide-by-2.
    function automatic logic [DIV_W-1:0] eff_ratio(input logic [DIV_W-1:0] r);
        eff_ratio = (r < DIV_W'(2)) ? DIV_W'(2) : r;
    endfunction

    assign running = (state_q != IDLE);

    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        act_d      = act_q;
        shd_d      = shd_q;
        cnt_d      = cnt_q;
        pend_d     = pend_q;
        adopted_d  = adopted_q;
        load_ack_d = 1'b0;
        adopt      = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            at_wrap[i] = (cnt_q[i] == eff_ratio(act_q[i]) - 1'b1);
        end

        if (!bus.enable) begin
            // Disable wins over a coincident running load; only IDLE loads survive.
            state_d    = IDLE;
            lock_cnt_d = '0;
            pend_d     = 1'b0;
            adopted_d  = '0;
            for (int i = 0; i < NUM_CH; i++) cnt_d[i] = '0;
            if (!running && bus.load) begin
                for (int i = 0; i < NUM_CH; i++) act_d[i] = bus.div_ratio[i*DIV_W +: DIV_W];
                load_ack_d = 1'b1;
            end
        end else if (!running) begin
            state_d    = SETTLE;
            lock_cnt_d = '0;
            for (int i = 0; i < NUM_CH; i++) cnt_d[i] = '0;
            if (bus.load) begin
                for (int i = 0; i < NUM_CH; i++) act_d[i] = bus.div_ratio[i*DIV_W +: DIV_W];
                load_ack_d = 1'b1;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_d[i] = at_wrap[i] ? '0 : cnt_q[i] + 1'b1;
            end
`ifdef CLK_GEN_MULTI_ALIGN_EN
            if (pend_q && at_wrap[0]) adopt = '1;
`else
            if (pend_q) adopt = at_wrap & ~adopted_q;
`endif
            for (int i = 0; i < NUM_CH; i++) begin
                if (adopt[i]) begin
                    act_d[i] = shd_q[i];
                    cnt_d[i] = '0;
                end
            end
            adopted_d = adopted_q | adopt;

            if (pend_q && (&adopted_d)) begin
                pend_d     = 1'b0;
                adopted_d  = '0;
                load_ack_d = 1'b1;
                lock_cnt_d = '0;
            end else if (pend_q) begin
                lock_cnt_d = '0;
            end else if (bus.load) begin
                for (int i = 0; i < NUM_CH; i++) shd_d[i] = bus.div_ratio[i*DIV_W +: DIV_W];
                pend_d     = 1'b1;
                adopted_d  = '0;
                state_d    = SETTLE;
                lock_cnt_d = '0;
            end else if (state_q == SETTLE) begin
                if (lock_cnt_q == LCW'(LOCK_CYCLES - 1)) state_d = LOCKED;
                else lock_cnt_d = lock_cnt_q + 1'b1;
            end
        end

        // Outputs are decoded from next-state counters so they register with zero input path.
        for (int i = 0; i < NUM_CH; i++) begin
            half[i]      = ({1'b0, eff_ratio(act_d[i])} + 1'b1) >> 1;
            clk_out_d[i] = (state_d != IDLE) && ({1'b0, cnt_d[i]} < half[i]);
            clk_en_d[i]  = (state_d != IDLE) && (cnt_d[i] == '0);
        end
        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk_in1 or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            lock_cnt_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                act_q[i] <= DIV_W'(2);
                shd_q[i] <= DIV_W'(2);
                cnt_q[i] <= '0;
            end
            pend_q     <= 1'b0;
            adopted_q  <= '0;
            clk_out_q  <= '0;
            clk_en_q   <= '0;
            load_ack_q <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
            for (int i = 0; i < NUM_CH; i++) begin
                act_q[i] <= act_d[i];
                shd_q[i] <= shd_d[i];
                cnt_q[i] <= cnt_d[i];
            end
            pend_q     <= pend_d;
            adopted_q  <= adopted_d;
            clk_out_q  <= clk_out_d;
            clk_en_q   <= clk_en_d;
            load_ack_q <= load_ack_d;
            locked_q   <= locked_d;
        end
    end

    assign bus.clk_out   = clk_out_q;
    assign bus.clk_en    = clk_en_q;
    assign bus.load_ack  = load_ack_q;
    assign bus.locked    = locked_q;
    assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_clk_gen_multi.sv
// Directed bench for clk_gen_multi (NUM_CH=4, DIV_W=8, LOCK_CYCLES=16) with hand-computed waveforms.
module tb_clk_gen_multi;
    logic clk;
    logic resetn;
    int   n_vec;
    int   n_err;
    int   n_ack;
    int   ack_k;

    clk_gen_multi_if #(.NUM_CH(4), .DIV_W(8)) bus ();

    clk_gen_multi #(.NUM_CH(4), .DIV_W(8), .LOCK_CYCLES(16)) dut (
        .clk_in1 (clk),
        .resetn  (resetn),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Ratios {ch3..ch0} = {0,5,4,3}: clk_out / clk_en nibbles for cycles 0..11 after enable.
    logic [3:0] t2_out [12] = '{4'hf, 4'h7, 4'hc, 4'h1, 4'hb, 4'h6, 4'hd, 4'h5, 4'ha, 4'h3, 4'hd, 4'h4};
    logic [3:0] t2_en  [12] = '{4'hf, 4'h0, 4'h8, 4'h1, 4'ha, 4'h4, 4'h9, 4'h0, 4'ha, 4'h1, 4'hc, 4'h0};
`ifdef CLK_GEN_MULTI_ALIGN_EN
    logic [3:0] t4_out [5]  = '{4'hf, 4'hf, 4'h0, 4'h0, 4'hf};
    logic [3:0] t4_en24     = 4'hf;
    logic [3:0] t4_en26     = 4'h0;
`else
    logic [3:0] t4_out [5]  = '{4'h1, 4'h1, 4'he, 4'he, 4'h1};
    logic [3:0] t4_en24     = 4'h1;
    logic [3:0] t4_en26     = 4'he;
`endif
    logic [3:0] t3_out [5]  = '{4'hf, 4'hd, 4'h7, 4'h9, 4'ha};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        resetn = 1'b0;
        bus.enable = 1'b0;
        bus.load = 1'b0;
        bus.div_ratio = '0;
        #3;
        check("rst_clk_out", 32'(bus.clk_out), 32'h0);
        check("rst_clk_en", 32'(bus.clk_en), 32'h0);
        check("rst_locked", 32'(bus.locked), 32'h0);
        check("rst_ack", 32'(bus.load_ack), 32'h0);
        check("rst_state", 32'(bus.state_dbg), 32'h0);

        // Default ratios, lock after 16 SETTLE cycles.
        #20;
        resetn = 1'b1;
        bus.enable = 1'b1;
        tick();
        check("t1_out0", 32'(bus.clk_out), 32'hf);
        check("t1_en0", 32'(bus.clk_en), 32'hf);
        check("t1_state0", 32'(bus.state_dbg), 32'h1);
        check("t1_lock0", 32'(bus.locked), 32'h0);
        for (int k = 1; k <= 15; k++) begin
            tick();
            check("t1_out", 32'(bus.clk_out), (k % 2 == 0) ? 32'hf : 32'h0);
            check("t1_lock", 32'(bus.locked), 32'h0);
        end
        tick();
        check("t1_locked", 32'(bus.locked), 32'h1);
        check("t1_state_l", 32'(bus.state_dbg), 32'h2);
        check("t1_out16", 32'(bus.clk_out), 32'hf);

        // Disable, then IDLE load {0,5,4,3}.
        bus.enable = 1'b0;
        tick();
        check("t2_dis_out", 32'(bus.clk_out), 32'h0);
        check("t2_dis_en", 32'(bus.clk_en), 32'h0);
        check("t2_dis_lock", 32'(bus.locked), 32'h0);
        check("t2_dis_state", 32'(bus.state_dbg), 32'h0);
        bus.div_ratio = {8'd0, 8'd5, 8'd4, 8'd3};
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        check("t2_ack", 32'(bus.load_ack), 32'h1);
        tick();
        check("t2_ack_low", 32'(bus.load_ack), 32'h0);
        bus.enable = 1'b1;
        tick();
        for (int k = 0; k < 12; k++) begin
            check("t2_out", 32'(bus.clk_out), 32'(t2_out[k]));
            check("t2_en", 32'(bus.clk_en), 32'(t2_en[k]));
            tick();
        end

        // Run at {4,4,4,4}, then load {3,6,2,8} while locked.
        bus.enable = 1'b0;
        tick();
        bus.div_ratio = 32'h04040404;
        bus.load = 1'b1;
        tick();
        check("t3_idle_ack", 32'(bus.load_ack), 32'h1);
        bus.load = 1'b0;
        bus.enable = 1'b1;
        tick();
        for (int k = 1; k <= 17; k++) tick();
        check("t3_pre_lock", 32'(bus.locked), 32'h1);
        check("t3_pre_out", 32'(bus.clk_out), 32'hf);
        bus.div_ratio = 32'h03060208;
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        check("t3_lock_drop", 32'(bus.locked), 32'h0);
        check("t3_state", 32'(bus.state_dbg), 32'h1);
        check("t3_out18", 32'(bus.clk_out), 32'h0);
        tick();
        check("t3_out19", 32'(bus.clk_out), 32'h0);
        check("t3_ack19", 32'(bus.load_ack), 32'h0);
        tick();
        check("t3_en20", 32'(bus.clk_en), 32'hf);
        check("t3_ack20", 32'(bus.load_ack), 32'h1);
        for (int k = 0; k < 5; k++) begin
            check("t3_out", 32'(bus.clk_out), 32'(t3_out[k]));
            if (k > 0) check("t3_ack_low", 32'(bus.load_ack), 32'h0);
            if (k < 4) tick();
        end
        for (int c = 25; c <= 35; c++) begin
            tick();
            check("t3_relock_wait", 32'(bus.locked), 32'h0);
        end
        tick();
        check("t3_relock", 32'(bus.locked), 32'h1);

        // Skewed adoption of {4,4,4,4}; second load while pending is ignored.
        bus.div_ratio = 32'h04040404;
        bus.load = 1'b1;
        n_ack = 0;
        ack_k = 0;
        tick();
        bus.load = 1'b0;
        check("t4_lock_drop", 32'(bus.locked), 32'h0);
        for (int k = 17; k <= 30; k++) begin
            if (bus.load_ack === 1'b1) begin
                n_ack++;
                ack_k = k;
            end
            if (k <= 23) check("t4_ch0_old", 32'(bus.clk_out[0]), (k <= 19) ? 32'h1 : 32'h0);
            if (k >= 24 && k <= 28) check("t4_out", 32'(bus.clk_out), 32'(t4_out[k-24]));
            if (k == 24) check("t4_en24", 32'(bus.clk_en), 32'(t4_en24));
            if (k == 26) check("t4_en26", 32'(bus.clk_en), 32'(t4_en26));
            if (k == 18) begin
                bus.div_ratio = 32'h07070707;
                bus.load = 1'b1;
            end else begin
                bus.load = 1'b0;
            end
            tick();
        end
        check("t4_ack_count", 32'(n_ack), 32'd1);
        check("t4_ack_cycle", 32'(ack_k), 32'd24);

        // Disable coincident with load, then reset pulse mid-SETTLE.
        bus.div_ratio = 32'h09090909;
        bus.load = 1'b1;
        bus.enable = 1'b0;
        tick();
        bus.load = 1'b0;
        check("t5_out", 32'(bus.clk_out), 32'h0);
        check("t5_en", 32'(bus.clk_en), 32'h0);
        check("t5_lock", 32'(bus.locked), 32'h0);
        check("t5_ack", 32'(bus.load_ack), 32'h0);
        check("t5_state", 32'(bus.state_dbg), 32'h0);
        tick();
        check("t5_ack_late", 32'(bus.load_ack), 32'h0);
        bus.enable = 1'b1;
        tick();
        check("t5_r0", 32'(bus.clk_out), 32'hf);
        tick();
        check("t5_r1", 32'(bus.clk_out), 32'hf);
        tick();
        check("t5_r2", 32'(bus.clk_out), 32'h0);
        tick();
        check("t5_r3", 32'(bus.clk_out), 32'h0);
        tick();
        check("t5_r4", 32'(bus.clk_out), 32'hf);
        #2;
        resetn = 1'b0;
        bus.enable = 1'b0;
        #1;
        check("t5_rst_out", 32'(bus.clk_out), 32'h0);
        check("t5_rst_en", 32'(bus.clk_en), 32'h0);
        check("t5_rst_state", 32'(bus.state_dbg), 32'h0);
        #3;
        resetn = 1'b1;
        bus.enable = 1'b1;
        tick();
        check("t5_d0", 32'(bus.clk_out), 32'hf);
        tick();
        check("t5_d1", 32'(bus.clk_out), 32'h0);
        check("t5_d1_en", 32'(bus.clk_en), 32'h0);
        tick();
        check("t5_d2", 32'(bus.clk_out), 32'hf);
        check("t5_d2_en", 32'(bus.clk_en), 32'hf);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
